// File: rtl/qerv_dbus_resp_if.sv
// qerv_dbus_resp_if: qerv data-bus request/response bundle
//   adr  32  byte address (bits [1:0] ignored by the responder)
//   dat  32  store data, lane-positioned
//   sel   4  byte-lane enables
//   we    1  1=store, 0=load
//   cyc   1  request valid, held until ack
//   rdt  32  load data, valid in the ack cycle
//   ack   1  one-cycle completion pulse
//   err   1  one-cycle out-of-range pulse, coincident with ack
interface qerv_dbus_resp_if;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic [31:0] rdt;
    logic        ack;
    logic        err;
    modport master (output adr, dat, sel, we, cyc, input rdt, ack, err);
    modport slave  (input adr, dat, sel, we, cyc, output rdt, ack, err);
endinterface

// File: rtl/qerv_dbus_resp.sv
// qerv_dbus_resp: dbus memory responder with byte-masked stores and wait states
//   clk  in   clock, rising edge
//   rst  in   asynchronous active-high reset
//   bus  slave modport of qerv_dbus_resp_if (adr/dat/sel/we/cyc in, rdt/ack/err out)
module qerv_dbus_resp #(
    parameter int AW     = 8,
    parameter int WAIT   = 2,
    parameter bit CHKOOR = 1'b1
) (
    input logic            clk,
    input logic            rst,
    qerv_dbus_resp_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAITS, XFER, ACK} state_t;
    localparam logic [3:0] CNT0 = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);
    state_t          state, state_n;
    logic [3:0]      cnt;
    logic [AW-1:0]   a_q;
    logic [31:0]     dat_q;
    logic [3:0]      sel_q;
    logic            we_q;
    logic            oor_q;
    logic [31:0]     rdt_q;
    logic            ack_q;
    logic            err_q;
    logic [31:0]     mem [2**AW];
    logic            oor_in;
    logic            unused_lsb;
    assign oor_in     = CHKOOR && ((bus.adr >> (AW + 2)) != 32'd0);
    assign unused_lsb = &{1'b0, bus.adr[1:0]};
    assign bus.rdt    = rdt_q;
    assign bus.ack    = ack_q;
    assign bus.err    = err_q;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.cyc) state_n = (WAIT == 0) ? XFER : WAITS;
            WAITS:   state_n = !bus.cyc ? IDLE : (cnt == 4'd0) ? XFER : WAITS;
            XFER:    state_n = ACK;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            rdt_q <= 32'd0;
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            // ack/err are registered straight out of XFER so they are high exactly in ACK
            ack_q <= state == XFER;
            err_q <= state == XFER && oor_q;
            if (state == IDLE && bus.cyc)
                cnt <= CNT0;
            else if (state == WAITS)
                cnt <= cnt - 4'd1;
            if (state == XFER && !we_q)
                rdt_q <= oor_q ? 32'd0 : mem[a_q];
        end
    end
    // Request fields are captured only when leaving IDLE; later bus changes are ignored
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.cyc) begin
            a_q   <= bus.adr[AW+1:2];
            dat_q <= bus.dat;
            sel_q <= bus.sel;
            we_q  <= bus.we;
            oor_q <= oor_in;
        end
    end
    // RAM is not reset; it is written only in XFER so an aborted request never commits
    always_ff @(posedge clk) begin
        if (state == XFER && we_q && !oor_q)
            for (int n = 0; n < 4; n++)
                if (sel_q[n]) mem[a_q][8*n +: 8] <= dat_q[8*n +: 8];
    end
endmodule

// File: tb/tb_qerv_dbus_resp.sv
// tb_qerv_dbus_resp: table-driven scoreboard bench for qerv_dbus_resp (WAIT=2 and WAIT=0)
module tb_qerv_dbus_resp;
    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] rdt;
        logic        err;
    } vec_t;
    typedef struct {
        logic [31:0] rdt;
        logic        err;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] adr = '0;
    logic [31:0] dat = '0;
    logic [3:0]  sel = '0;
    logic        we = 1'b0;
    logic        cyc0 = 1'b0;
    logic        cyc1 = 1'b0;
    int          total = 0;
    int          bad = 0;
    exp_t        sq[$];
    vec_t        tv[16];
    logic        prev0 = 1'b0;
    logic        prev1 = 1'b0;
    qerv_dbus_resp_if b0();
    qerv_dbus_resp_if b1();
    assign b0.adr = adr;
    assign b0.dat = dat;
    assign b0.sel = sel;
    assign b0.we  = we;
    assign b0.cyc = cyc0;
    assign b1.adr = adr;
    assign b1.dat = dat;
    assign b1.sel = sel;
    assign b1.we  = we;
    assign b1.cyc = cyc1;
    qerv_dbus_resp #(.AW(8), .WAIT(2), .CHKOOR(1'b1)) u0 (.clk(clk), .rst(rst), .bus(b0));
    qerv_dbus_resp #(.AW(8), .WAIT(0), .CHKOOR(1'b1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask
    // Scoreboard: every ack pops the oldest expected response
    always @(negedge clk) begin
        if (b0.ack) chk("no_back2back_ack0", {31'd0, prev0}, 32'd0);
        if (b1.ack) chk("no_back2back_ack1", {31'd0, prev1}, 32'd0);
        if (b0.ack || b1.ack) begin
            if (sq.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sq.pop_front();
                chk("rdt", b0.ack ? b0.rdt : b1.rdt, e.rdt);
                chk("err", {31'd0, b0.ack ? b0.err : b1.err}, {31'd0, e.err});
            end
        end
        prev0 <= b0.ack;
        prev1 <= b1.ack;
    end
    task automatic xact(input int d, input logic w, input logic [31:0] a, input logic [31:0] v,
                        input logic [3:0] s, input logic [31:0] er, input logic ee, input logic chg);
        int lat;
        @(posedge clk);
        #1;
        we = w; adr = a; dat = v; sel = s;
        sq.push_back('{er, ee});
        if (d == 0) cyc0 = 1'b1; else cyc1 = 1'b1;
        lat = 0;
        for (int i = 1; i <= 30 && lat == 0; i++) begin
            @(posedge clk);
            #1;
            if (chg && i == 1) begin
                adr = a + 32'd4;
                dat = ~v;
            end
            if ((d == 0) ? b0.ack : b1.ack) lat = i;
        end
        cyc0 = 1'b0;
        cyc1 = 1'b0;
        if (lat == 0 && sq.size() > 0) void'(sq.pop_back());
        chk("latency", 32'(lat), (d == 0) ? 32'd4 : 32'd2);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [6:0] acks;
        logic       got;
        tv[0]  = '{1'b1, 32'h0000_0000, 32'h0102_0304, 4'hF, 32'h0000_0000, 1'b0};
        tv[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
        tv[2]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0};
        tv[3]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'hF, 32'hDEAD_BEEF, 1'b0};
        tv[4]  = '{1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'h5, 32'hDEAD_BEEF, 1'b0};
        tv[5]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'h11BB_33DD, 1'b0};
        tv[6]  = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 32'h11BB_33DD, 1'b0};
        tv[7]  = '{1'b0, 32'h0000_0012, 32'h0,         4'hF, 32'h11BB_33DD, 1'b0};
        tv[8]  = '{1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 4'hF, 32'h11BB_33DD, 1'b0};
        tv[9]  = '{1'b1, 32'h0000_03FC, 32'h5A5A_5A5A, 4'hA, 32'h11BB_33DD, 1'b0};
        tv[10] = '{1'b0, 32'h0000_03FF, 32'h0,         4'hF, 32'h5AA5_5AA5, 1'b0};
        tv[11] = '{1'b0, 32'h0000_0400, 32'h0,         4'hF, 32'h0000_0000, 1'b1};
        tv[12] = '{1'b1, 32'h0000_0400, 32'h9999_9999, 4'hF, 32'h0000_0000, 1'b1};
        tv[13] = '{1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'h0102_0304, 1'b0};
        tv[14] = '{1'b0, 32'h0800_0000, 32'h0,         4'hF, 32'h0000_0000, 1'b1};
        tv[15] = '{1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'h0102_0304, 1'b0};
        idle(2);
        #2 rst = 1'b0;
        chk("reset_ack0", {31'd0, b0.ack}, 32'd0);
        chk("reset_err0", {31'd0, b0.err}, 32'd0);
        chk("reset_rdt0", b0.rdt, 32'd0);
        chk("reset_rdt1", b1.rdt, 32'd0);
        for (int i = 0; i < 16; i++)
            xact(0, tv[i].we, tv[i].adr, tv[i].dat, tv[i].sel, tv[i].rdt, tv[i].err, 1'b0);
        // Abort: cyc high for one cycle only, dropped while in WAITS
        @(posedge clk);
        #1;
        we = 1'b1; adr = 32'h10; dat = 32'h0; sel = 4'hF; cyc0 = 1'b1;
        @(posedge clk);
        #1 cyc0 = 1'b0;
        idle(8);
        xact(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'h11BB_33DD, 1'b0, 1'b0);
        // Bus changes after the request is latched must be ignored
        xact(0, 1'b1, 32'h24, 32'h2468_ACE0, 4'hF, 32'h11BB_33DD, 1'b0, 1'b0);
        xact(0, 1'b1, 32'h20, 32'h1357_9BDF, 4'hF, 32'h11BB_33DD, 1'b0, 1'b1);
        xact(0, 1'b0, 32'h20, 32'h0, 4'hF, 32'h1357_9BDF, 1'b0, 1'b0);
        xact(0, 1'b0, 32'h24, 32'h0, 4'hF, 32'h2468_ACE0, 1'b0, 1'b0);
        // WAIT=0 with cyc held across ack: acks in cycles 2 and 5 only
        sq.push_back('{32'h0, 1'b0});
        sq.push_back('{32'h0, 1'b0});
        @(posedge clk);
        #1;
        we = 1'b1; adr = 32'h8; dat = 32'hCAFE_F00D; sel = 4'hF; cyc1 = 1'b1;
        acks = '0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1 acks[i] = b1.ack;
        end
        cyc1 = 1'b0;
        chk("wait0_ack_pattern", {25'd0, acks}, 32'h24);
        idle(3);
        while (sq.size() > 1) void'(sq.pop_front());
        sq.delete();
        xact(1, 1'b0, 32'h8, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0, 1'b0);
        // Async reset in the ack cycle clears outputs immediately
        @(posedge clk);
        #1;
        we = 1'b0; adr = 32'h10; cyc0 = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(posedge clk);
            #1 got = b0.ack;
        end
        chk("rst_pre_ack", {31'd0, got}, 32'd1);
        chk("rst_pre_rdt", b0.rdt, 32'h11BB_33DD);
        #1 rst = 1'b1;
        cyc0 = 1'b0;
        #1;
        chk("rst_async_ack", {31'd0, b0.ack}, 32'd0);
        chk("rst_async_err", {31'd0, b0.err}, 32'd0);
        chk("rst_async_rdt", b0.rdt, 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        // Reset during WAITS of a store must not commit it
        @(posedge clk);
        #1;
        we = 1'b1; adr = 32'h10; dat = 32'h0; sel = 4'hF; cyc0 = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        cyc0 = 1'b0;
        #2 rst = 1'b0;
        idle(8);
        xact(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'h11BB_33DD, 1'b0, 1'b0);
        idle(2);
        chk("queue_drained", 32'(sq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
